// File: rtl/progmem_pkg.sv
// Shared types and helpers for the program-memory access controller.
//   spm_cmd_e : SPM command encoding as driven on spm_cmd
//   state_e   : sequencer states
//   is_nrww() : true when a page index lies in the NRWW section
package progmem_pkg;

  localparam int unsigned PAGE_OFS_W = 7;
  localparam int unsigned PAGE_IDX_W = 8;

  typedef enum logic [1:0] {
    CmdBufWr   = 2'b00,
    CmdPgErase = 2'b01,
    CmdPgWrite = 2'b10,
    CmdRwwEn   = 2'b11
  } spm_cmd_e;

  typedef enum logic [1:0] {
    StIdle,
    StErase,
    StProg,
    StDone
  } state_e;

  function automatic logic is_nrww(input logic [PAGE_IDX_W-1:0] page,
                                   input logic [PAGE_IDX_W-1:0] first_page);
    return page >= first_page;
  endfunction

endpackage

// File: rtl/progmem_op_timer.sv
// Loadable down-counter with a zero flag, used to time page erase and page write.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (takes precedence over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement request; the count saturates at zero
//   zero_o     : count is zero
module progmem_op_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] count_q, count_d;

  assign zero_o = (count_q == '0);

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/progmem_access_ctrl.sv
// Program-memory access controller: arbitrates the single array read port between
// CPU fetch and LPM, sequences SPM commands and enforces Read-While-Write rules.
//   clk, rst                       : clock, synchronous active-high reset
//   fetch_req/fetch_pc/fetch_stall : CPU instruction fetch (word address)
//   lpm_req/lpm_addr/lpm_gnt       : LPM data read (byte address)
//   rd_sel_lpm                     : read-port owner, 1 = LPM
//   spm_req/cmd/addr/wdata/ack     : SPM command interface
//   mem_*                          : array control (read, buffer write, erase, program)
//   rwwsb, rdy                     : RWW-section busy and operation-idle flags
module progmem_access_ctrl
  import progmem_pkg::*;
#(
  parameter int unsigned              PAGE_BYTES      = 2 ** PAGE_OFS_W,
  parameter int unsigned              NUM_PAGES       = 2 ** PAGE_IDX_W,
  parameter logic [PAGE_IDX_W-1:0]    NRWW_FIRST_PAGE = 8'hE0,
  parameter int unsigned              T_ERASE_CYC     = 16,
  parameter int unsigned              T_PROG_CYC      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [13:0] fetch_pc,
  output logic        fetch_stall,
  input  logic        lpm_req,
  input  logic [14:0] lpm_addr,
  output logic        lpm_gnt,
  output logic        rd_sel_lpm,
  input  logic        spm_req,
  input  logic [1:0]  spm_cmd,
  input  logic [14:0] spm_addr,
  input  logic [15:0] spm_wdata,
  output logic        spm_ack,
  output logic        mem_rd,
  output logic [14:0] mem_addr,
  output logic        mem_buf_wr,
  output logic        mem_erase,
  output logic        mem_prog,
  output logic [15:0] mem_wdata,
  output logic        rwwsb,
  output logic        rdy
);

  localparam int unsigned OfsW    = $clog2(PAGE_BYTES);
  localparam int unsigned IdxW    = $clog2(NUM_PAGES);
  localparam int unsigned TMaxCyc = (T_ERASE_CYC > T_PROG_CYC) ? T_ERASE_CYC : T_PROG_CYC;
  localparam int unsigned TimerW  = (TMaxCyc > 2) ? $clog2(TMaxCyc) : 1;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   page_q, page_d;
  logic              rwwsb_q, rwwsb_d;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic [TimerW-1:0] tmr_val;

  logic [IdxW-1:0] req_page;
  logic [14:0]     fetch_addr;
  logic            busy, restricted;

  assign req_page   = spm_addr[OfsW +: IdxW];
  assign fetch_addr = {fetch_pc, 1'b0};
  assign busy       = (state_q == StErase) || (state_q == StProg);
  assign restricted = busy || rwwsb_q;

  assign mem_erase = (state_q == StErase);
  assign mem_prog  = (state_q == StProg);
  assign rdy       = !busy;
  assign rwwsb     = rwwsb_q;

  progmem_op_timer #(
    .Width(TimerW)
  ) u_op_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  // Sequencer
  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    rwwsb_d    = rwwsb_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    tmr_dec    = 1'b0;
    spm_ack    = 1'b0;
    mem_buf_wr = 1'b0;
    mem_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (spm_req) begin
          spm_ack = 1'b1;
          unique case (spm_cmd_e'(spm_cmd))
            CmdBufWr: begin
              mem_buf_wr = 1'b1;
              mem_wdata  = spm_wdata;
            end
            CmdPgErase, CmdPgWrite: begin
              page_d   = req_page;
              tmr_load = 1'b1;
              if (spm_cmd_e'(spm_cmd) == CmdPgErase) begin
                tmr_val = TimerW'(T_ERASE_CYC - 1);
                state_d = StErase;
              end else begin
                tmr_val = TimerW'(T_PROG_CYC - 1);
                state_d = StProg;
              end
              if (!is_nrww(req_page, NRWW_FIRST_PAGE)) begin
                rwwsb_d = 1'b1;
              end
            end
            CmdRwwEn: rwwsb_d = 1'b0;
            default: ;
          endcase
        end
      end
      StErase, StProg: begin
        tmr_dec = 1'b1;
        if (tmr_zero) begin
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Read-port arbitration
  always_comb begin
    mem_rd      = 1'b0;
    mem_addr    = busy ? {page_q, {OfsW{1'b0}}} : '0;
    lpm_gnt     = 1'b0;
    rd_sel_lpm  = 1'b0;
    fetch_stall = 1'b0;
    if (mem_buf_wr) begin
      // The buffer write owns mem_addr this cycle, so no read is served.
      mem_addr    = spm_addr;
      fetch_stall = fetch_req;
    end else if (busy && is_nrww(page_q, NRWW_FIRST_PAGE)) begin
      fetch_stall = fetch_req;
    end else if (lpm_req) begin
      lpm_gnt     = 1'b1;
      rd_sel_lpm  = 1'b1;
      fetch_stall = fetch_req;
      // LPM into a busy RWW section is granted but returns undefined data.
      if (!restricted || is_nrww(lpm_addr[OfsW +: IdxW], NRWW_FIRST_PAGE)) begin
        mem_rd   = 1'b1;
        mem_addr = lpm_addr;
      end
    end else if (fetch_req) begin
      if (!restricted || is_nrww(fetch_addr[OfsW +: IdxW], NRWW_FIRST_PAGE)) begin
        mem_rd   = 1'b1;
        mem_addr = fetch_addr;
      end else begin
        fetch_stall = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      page_q  <= '0;
      rwwsb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      rwwsb_q <= rwwsb_d;
    end
  end

endmodule

// File: tb/tb_progmem_access_ctrl.sv
module tb_progmem_access_ctrl;

  localparam int TErase   = 16;
  localparam int TProg    = 16;
  localparam int NrwwPage = 'hE0;
  localparam int NrwwByte = NrwwPage * 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [13:0] fetch_pc;
  logic        fetch_stall;
  logic        lpm_req;
  logic [14:0] lpm_addr;
  logic        lpm_gnt;
  logic        rd_sel_lpm;
  logic        spm_req;
  logic [1:0]  spm_cmd;
  logic [14:0] spm_addr;
  logic [15:0] spm_wdata;
  logic        spm_ack;
  logic        mem_rd;
  logic [14:0] mem_addr;
  logic        mem_buf_wr;
  logic        mem_erase;
  logic        mem_prog;
  logic [15:0] mem_wdata;
  logic        rwwsb;
  logic        rdy;

  always #5 clk = ~clk;

  progmem_access_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_pc   (fetch_pc),
    .fetch_stall(fetch_stall),
    .lpm_req    (lpm_req),
    .lpm_addr   (lpm_addr),
    .lpm_gnt    (lpm_gnt),
    .rd_sel_lpm (rd_sel_lpm),
    .spm_req    (spm_req),
    .spm_cmd    (spm_cmd),
    .spm_addr   (spm_addr),
    .spm_wdata  (spm_wdata),
    .spm_ack    (spm_ack),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_buf_wr (mem_buf_wr),
    .mem_erase  (mem_erase),
    .mem_prog   (mem_prog),
    .mem_wdata  (mem_wdata),
    .rwwsb      (rwwsb),
    .rdy        (rdy)
  );

  typedef struct packed {
    logic        fetch_stall;
    logic        lpm_gnt;
    logic        rd_sel_lpm;
    logic        spm_ack;
    logic        mem_rd;
    logic [14:0] mem_addr;
    logic        mem_buf_wr;
    logic        mem_erase;
    logic        mem_prog;
    logic [15:0] mem_wdata;
    logic        rwwsb;
    logic        rdy;
  } outs_t;

  typedef struct {
    logic        freq;
    logic [13:0] pc;
    logic        lreq;
    logic [14:0] la;
    logic        rd;
    logic [14:0] addr;
    logic        gnt;
    logic        stall;
    logic        sel;
  } vec_t;

  outs_t act, exp_o;
  vec_t  vecs[6];
  int    n_checks = 0;
  int    n_err    = 0;
  int    cyc      = 0;

  // Reference model: remaining busy cycles, operation kind, target page, flags
  int m_left, m_page;
  bit m_prog, m_rwwsb, m_done;

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_page = 0; m_prog = 0; m_rwwsb = 0; m_done = 0;
  endtask

  function automatic outs_t model_out();
    outs_t e;
    int    fa;
    bit    busy, idle, restr;
    e     = '0;
    busy  = m_left > 0;
    idle  = !busy && !m_done;
    restr = busy || m_rwwsb;
    fa    = int'(fetch_pc) * 2;
    e.rdy   = !busy;
    e.rwwsb = m_rwwsb;
    if (busy) begin
      e.mem_erase = !m_prog;
      e.mem_prog  = m_prog;
      e.mem_addr  = 15'(m_page * 128);
    end
    if (idle && spm_req) e.spm_ack = 1'b1;
    if (idle && spm_req && spm_cmd == 2'b00) begin
      e.mem_buf_wr  = 1'b1;
      e.mem_wdata   = spm_wdata;
      e.mem_addr    = spm_addr;
      e.fetch_stall = fetch_req;
    end else if (busy && m_page >= NrwwPage) begin
      e.fetch_stall = fetch_req;
    end else if (lpm_req) begin
      e.lpm_gnt     = 1'b1;
      e.rd_sel_lpm  = 1'b1;
      e.fetch_stall = fetch_req;
      if (!restr || int'(lpm_addr) >= NrwwByte) begin
        e.mem_rd   = 1'b1;
        e.mem_addr = lpm_addr;
      end
    end else if (fetch_req) begin
      if (!restr || fa >= NrwwByte) begin
        e.mem_rd   = 1'b1;
        e.mem_addr = 15'(fa);
      end else begin
        e.fetch_stall = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_tick();
    if (rst) begin
      model_reset();
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (spm_req && spm_cmd != 2'b00) begin
      if (spm_cmd == 2'b11) begin
        m_rwwsb = 0;
      end else begin
        m_prog = (spm_cmd == 2'b10);
        m_left = m_prog ? TProg : TErase;
        m_page = int'(spm_addr) / 128;
        if (m_page < NrwwPage) m_rwwsb = 1;
      end
    end
  endtask

  task automatic idle_inputs();
    rst = 0; fetch_req = 0; fetch_pc = '0; lpm_req = 0; lpm_addr = '0;
    spm_req = 0; spm_cmd = '0; spm_addr = '0; spm_wdata = '0;
  endtask

  task automatic spm(input logic [1:0] cmd, input logic [14:0] addr, input logic [15:0] wd);
    idle_inputs();
    spm_req = 1; spm_cmd = cmd; spm_addr = addr; spm_wdata = wd;
  endtask

  // One clock: sample and check mid-cycle, then advance the model at the edge
  task automatic step();
    @(negedge clk);
    act = {fetch_stall, lpm_gnt, rd_sel_lpm, spm_ack, mem_rd, mem_addr, mem_buf_wr,
           mem_erase, mem_prog, mem_wdata, rwwsb, rdy};
    exp_o = model_out();
    chk($sformatf("model_cyc%0d", cyc), 64'(act), 64'(exp_o));
    @(posedge clk);
    model_tick();
    cyc++;
    #1;
  endtask

  int cnt, cnt2, cnt3;

  initial begin
    vecs[0] = '{1'b1, 14'h0041, 1'b1, 15'h1C02, 1'b1, 15'h1C02, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 14'h0041, 1'b0, 15'h0000, 1'b1, 15'h0082, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 14'h0000, 1'b1, 15'h7FFF, 1'b1, 15'h7FFF, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 14'h3FFF, 1'b0, 15'h0000, 1'b1, 15'h7FFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 14'h0000, 1'b0, 15'h0000, 1'b0, 15'h0000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 14'h3820, 1'b1, 15'h0005, 1'b1, 15'h0005, 1'b1, 1'b1, 1'b1};

    model_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    chk("reset_outs", 64'(act), 64'(outs_t'(41'h1)));
    rst = 0;

    // Idle arbitration table
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      fetch_req = vecs[i].freq; fetch_pc = vecs[i].pc;
      lpm_req = vecs[i].lreq; lpm_addr = vecs[i].la;
      step();
      chk($sformatf("arb_vec%0d", i),
          {act.mem_rd, act.mem_addr, act.lpm_gnt, act.fetch_stall, act.rd_sel_lpm},
          {vecs[i].rd, vecs[i].addr, vecs[i].gnt, vecs[i].stall, vecs[i].sel});
    end

    // RWW page erase with busy rejection and reads during the operation
    spm(2'b01, 15'h0080, 16'h0);
    step();
    chk("erase_ack", act.spm_ack, 1);
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      case (i)
        2: begin spm_req = 1; spm_cmd = 2'b10; spm_addr = 15'h7080; end
        3: begin spm_req = 1; spm_cmd = 2'b11; end
        5: begin fetch_req = 1; fetch_pc = 14'h3820; end
        6: begin fetch_req = 1; fetch_pc = 14'h0041; end
        default: ;
      endcase
      step();
      case (i)
        2: chk("busy_pgwrite_ack", act.spm_ack, 0);
        3: chk("busy_rwwen_rwwsb", {act.spm_ack, act.rwwsb}, 2'b01);
        5: chk("rww_nrww_fetch", {act.fetch_stall, act.mem_rd, act.mem_addr}, {2'b01, 15'h7040});
        6: chk("rww_rww_fetch", {act.fetch_stall, act.mem_rd}, 2'b10);
        default: ;
      endcase
      if (!act.rdy) cnt2++;
      if (act.mem_erase) cnt++;
      else break;
    end
    chk("erase_len", cnt, TErase);
    chk("erase_rdy_low", cnt2, TErase);
    chk("erase_done_rwwsb", {act.rwwsb, act.rdy}, 2'b11);
    idle_inputs(); fetch_req = 1; fetch_pc = 14'h0041;
    step();
    chk("post_erase_stall", act.fetch_stall, 1);
    spm(2'b11, 15'h0, 16'h0);
    step();
    chk("rwwen_ack", act.spm_ack, 1);
    idle_inputs(); fetch_req = 1; fetch_pc = 14'h0041;
    step();
    chk("rwwen_fetch", {act.fetch_stall, act.mem_rd, act.rwwsb, act.mem_addr}, {3'b010, 15'h0082});

    // NRWW page write preceded by two buffer writes
    spm(2'b00, {8'hE1, 7'd2}, 16'h6699);
    step();
    chk("bufwr0", {act.mem_buf_wr, act.spm_ack, act.mem_addr, act.mem_wdata},
        {2'b11, 15'h7082, 16'h6699});
    spm(2'b00, {8'hE1, 7'd4}, 16'hABCD);
    step();
    chk("bufwr1", {act.mem_buf_wr, act.spm_ack, act.mem_addr, act.mem_wdata},
        {2'b11, 15'h7084, 16'hABCD});
    spm(2'b10, 15'h7080, 16'h0);
    step();
    chk("prog_ack", act.spm_ack, 1);
    cnt = 0; cnt2 = 0; cnt3 = 0;
    for (int i = 0; i < 40; i++) begin
      idle_inputs(); fetch_req = 1; fetch_pc = 14'h3820;
      step();
      if (act.rwwsb) cnt3++;
      if (act.mem_prog) begin
        cnt++;
        if (act.fetch_stall) cnt2++;
      end else break;
    end
    chk("prog_len", cnt, TProg);
    chk("prog_stall", cnt2, TProg);
    chk("prog_rwwsb", cnt3, 0);

    // Reset in the fifth cycle of an RWW page write
    spm(2'b10, 15'h0180, 16'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      step();
    end
    idle_inputs(); rst = 1;
    step();
    chk("pre_rst_prog", {act.mem_prog, act.rwwsb}, 2'b11);
    idle_inputs();
    step();
    chk("rst_abort", {act.mem_prog, act.rdy, act.rwwsb}, 3'b010);
    spm(2'b01, 15'h7000, 16'h0);
    step();
    chk("post_rst_ack", act.spm_ack, 1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      idle_inputs();
      step();
      if (act.mem_erase) cnt++;
      else break;
    end
    chk("post_rst_erase_len", cnt, TErase);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      fetch_req = 1'($urandom_range(0, 1));
      fetch_pc  = $urandom_range(0, 1) ? 14'($urandom) : {3'b111, 11'($urandom)};
      lpm_req   = ($urandom_range(0, 2) == 0);
      lpm_addr  = $urandom_range(0, 1) ? 15'($urandom) : {3'b111, 12'($urandom)};
      spm_req   = ($urandom_range(0, 5) == 0);
      spm_cmd   = 2'($urandom);
      spm_addr  = $urandom_range(0, 1) ? 15'($urandom) : {3'b111, 12'($urandom)};
      spm_wdata = 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/progmem_access_ctrl.md
Name: progmem_access_ctrl

Overview:
- Sequencer and arbiter in front of the program-memory array (256 pages x 128 bytes; pages 0xE0-0xFF form the NRWW section, the rest is RWW).
- Shares the single read port between CPU instruction fetch and LPM data reads.
- Sequences SPM self-programming commands: page-buffer write, page erase, page write, RWW re-enable.
- Enforces Read-While-Write rules: CPU stall, the RWWSB busy flag, and the RDY flag.

Parameters:
- PAGE_BYTES, 128, bytes per page; sets byte-offset width to 7.
- NUM_PAGES, 256, total pages; sets page-index width to 8.
- NRWW_FIRST_PAGE, 8'hE0, first page of the NRWW section.
- T_ERASE_CYC, 16, clk cycles a page erase holds mem_erase.
- T_PROG_CYC, 16, clk cycles a page write holds mem_prog.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  CPU fetch request (PC_RD)
- fetch_pc  in  14  word address of the fetch
- fetch_stall  out  1  fetch not served this cycle; hold PC
- lpm_req  in  1  LPM read request
- lpm_addr  in  15  byte address for LPM
- lpm_gnt  out  1  LPM read served this cycle
- rd_sel_lpm  out  1  read-port owner: 1 = LPM, 0 = fetch
- spm_req  in  1  SPM command strobe, one cycle
- spm_cmd  in  2  00 BUF_WR, 01 PG_ERASE, 10 PG_WRITE, 11 RWW_EN
- spm_addr  in  15  byte address (page and offset)
- spm_wdata  in  16  word for BUF_WR
- spm_ack  out  1  command accepted, one-cycle pulse
- mem_rd  out  1  array read enable
- mem_addr  out  15  array byte address (bit 0 = 0 for word access)
- mem_buf_wr  out  1  write spm_wdata into page buffer at mem_addr[6:1]
- mem_erase  out  1  erase page mem_addr[14:7]
- mem_prog  out  1  program buffer into page mem_addr[14:7]
- mem_wdata  out  16  buffer write data
- rwwsb  out  1  RWW section busy
- rdy  out  1  no erase/program in progress

Behaviour:
- Reset values: all outputs 0 except rdy=1. FSM goes to IDLE. Timer = 0. Captured page = 0.
- FSM states: IDLE, ERASE, PROG, DONE.
- IDLE + spm_req:
  - BUF_WR: mem_buf_wr=1 for one cycle; spm_ack in the same cycle; stay IDLE.
  - PG_ERASE: capture page = spm_addr[14:7]; timer = T_ERASE_CYC-1; go to ERASE.
  - PG_WRITE: capture page; timer = T_PROG_CYC-1; go to PROG.
  - RWW_EN: clear rwwsb; spm_ack.
  - ERASE and PROG entries pulse spm_ack on the entry cycle.
- ERASE/PROG:
  - mem_erase/mem_prog held high every cycle; mem_addr = {captured page, 7'b0}; rdy=0.
  - Timer decrements each cycle; when it reaches 0, go to DONE.
  - Total hold time is exactly T_*_CYC cycles.
- DONE: rdy=1, strobes drop; go to IDLE next cycle. One cycle, so a new command is accepted 1 cycle after rdy rises.
- spm_req while not IDLE: ignored; no spm_ack, no state change.
- RWW_EN while rwwsb=1 and not rdy: ignored.
- rwwsb:
  - Set on entry to ERASE/PROG when the captured page < NRWW_FIRST_PAGE.
  - Stays set after completion until RWW_EN is executed in IDLE.
- Read arbitration in IDLE/DONE:
  - LPM has priority: lpm_req -> mem_rd=1, mem_addr=lpm_addr, rd_sel_lpm=1, lpm_gnt=1. A simultaneous fetch_req gets fetch_stall=1.
  - Otherwise fetch_req -> mem_rd=1, mem_addr={fetch_pc,1'b0}, fetch_stall=0.
- Reads during ERASE/PROG, NRWW target: CPU halted. fetch_stall=1 for any fetch_req, and lpm_gnt=0.
- Reads during ERASE/PROG, RWW target, and any time rwwsb=1:
  - Fetches/LPM to pages >= NRWW_FIRST_PAGE are served as above.
  - Fetches to RWW pages stall.
  - LPM to RWW pages is granted but mem_rd=0 (data undefined, per AVR rule).
- Array port sharing:
  - mem_rd and mem_erase/mem_prog are never high together on the same page.
  - A served read during RWW ops drives mem_addr to the read address. The array latches the erase/prog page at the ERASE/PROG entry cycle.
- Address width: fetch_pc is zero-extended by a left shift. PC 14'h3FFF maps to byte 15'h7FFE; no wrap handling is needed.
- Reset mid-operation: immediate abort. Strobes drop the same cycle rst is sampled, rwwsb=0, rdy=1. The array content of the aborted page is don't-care.

Decomposition:
- Package progmem_pkg holds:
  - spm_cmd_e enum (BUF_WR, PG_ERASE, PG_WRITE, RWW_EN).
  - state_e enum.
  - localparams PAGE_OFS_W=7, PAGE_IDX_W=8.
  - is_nrww(page) function.
- One sub-module, progmem_op_timer: loadable down-counter with a zero flag. Reused for the erase and program durations.

Test Plan:
- Idle arbitration: fetch_req with fetch_pc=14'h0041 and lpm_req with lpm_addr=15'h1C02 in the same cycle -> mem_addr=15'h1C02, lpm_gnt=1, fetch_stall=1. Next cycle fetch only -> mem_addr=15'h0082, fetch_stall=0.
- RWW page erase: PG_ERASE at spm_addr=15'h0080 (page 1) -> spm_ack pulse, mem_erase high exactly 16 cycles, rwwsb=1, rdy=0 for 16 cycles. Fetch at PC 14'h3820 (NRWW) is served; fetch at PC 14'h0041 stalls. After done, rwwsb stays 1 until RWW_EN, then that fetch is served.
- NRWW page write: BUF_WR x2 at offsets 2,4 with data 16'h6699, 16'hABCD -> two mem_buf_wr pulses. PG_WRITE at page 8'hE1 -> mem_prog 16 cycles, fetch_stall=1 throughout, rwwsb stays 0.
- Busy rejection: spm_req PG_WRITE while in ERASE -> no spm_ack, erase duration unchanged. RWW_EN during ERASE -> ignored.
- Reset mid-op: assert rst on cycle 5 of PROG -> next edge mem_prog=0, rdy=1, rwwsb=0, state IDLE. A following PG_ERASE is accepted.
